ntt_stream_adapter: RTL

- Streaming front/back end for the forward NTT core: accepts one polynomial of N coefficients on a valid/ready input stream and writes them into the core's load port.
- Pulses the core's start, waits for done, then drains the results through the core's synchronous read port onto a valid/ready output stream with last-beat marking.
- Sits directly between the system datapath and the NTT core. Processes one frame at a time.

---
 rtl/ntt_stream_adapter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ntt_stream_adapter.sv
// Streaming adapter around the forward NTT core: loads one frame, starts the core, drains results.
// Define NTT_ADAPTER_BITREV_OUT_EN to read results in bit-reversed address order (natural-order output).
module ntt_stream_adapter #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  ntt_load_coeff,
  output logic [ADDR_WIDTH-1:0] ntt_load_addr,
  output logic [WIDTH-1:0]      ntt_load_data,
  output logic                  ntt_start,
  input  logic                  ntt_done,
  input  logic                  ntt_busy,
  output logic [ADDR_WIDTH-1:0] ntt_read_addr,
  input  logic [WIDTH-1:0]      ntt_read_data,
  output logic                  len_err,
  output logic [1:0]            dbg_state_o
);

  // Both streams: a beat transfers on a rising edge where valid && ready; valid never
  // waits on ready, and an offered output beat stays stable until it is taken.

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   N_CNT    = (ADDR_WIDTH + 1)'(N);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic                    ntt_start_q, ntt_start_d;
  logic                    wait_armed_q, wait_armed_d;
  logic                    len_err_q, len_err_d;
  logic                    inflight_q, inflight_last_q;

  logic [WIDTH-1:0]        fifo_data_q [2];
  logic [1:0]              fifo_last_q;
  logic                    fifo_wptr_q, fifo_rptr_q;
  logic [1:0]              fifo_cnt_q;

  logic                    pop, push, issue, issue_last;
  logic [1:0]              occ_total;
  logic [ADDR_WIDTH-1:0]   rd_idx, issue_addr;

`ifdef NTT_ADAPTER_BITREV_OUT_EN
  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
    return r;
  endfunction
`endif

  assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];
`ifdef NTT_ADAPTER_BITREV_OUT_EN
  assign issue_addr = bitrev(rd_idx);
`else
  assign issue_addr = rd_idx;
`endif

  // Output FIFO bookkeeping: a read issued this cycle lands in the FIFO next cycle,
  // so the in-flight slot counts against the two entries.
  assign m_valid    = (fifo_cnt_q != 2'd0);
  assign m_data     = fifo_data_q[fifo_rptr_q];
  assign m_last     = m_valid && fifo_last_q[fifo_rptr_q];
  assign pop        = m_valid && m_ready;
  assign push       = inflight_q;
  assign occ_total  = fifo_cnt_q + {1'b0, inflight_q};
  assign issue      = (state_q == ST_UNLOAD) && (rd_ptr_q < N_CNT) &&
                      (occ_total < (2'd2 + {1'b0, pop}));
  assign issue_last = (rd_idx == LAST_IDX);

  assign ntt_read_addr = issue ? issue_addr : raddr_q;
  assign ntt_load_addr = wr_cnt_q;
  assign ntt_load_data = s_data;
  assign ntt_start     = ntt_start_q;
  assign len_err       = len_err_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_ptr_d       = rd_ptr_q;
    out_cnt_d      = out_cnt_q;
    len_err_d      = len_err_q;
    ntt_start_d    = 1'b0;
    wait_armed_d   = 1'b0;
    s_ready        = 1'b0;
    ntt_load_coeff = 1'b0;
    case (state_q)
      ST_LOAD: begin
        s_ready        = !ntt_busy;
        ntt_load_coeff = s_valid && !ntt_busy;
        if (s_valid && !ntt_busy) begin
          // s_last only flags a length mismatch; the frame is always N beats.
          if (s_last != (wr_cnt_q == LAST_IDX)) len_err_d = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d    = '0;
            ntt_start_d = 1'b1;
            state_d     = ST_START;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // The first WAIT cycle ignores done; the core may still show the previous frame's.
        wait_armed_d = 1'b1;
        if (wait_armed_q && ntt_done && !ntt_busy) state_d = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (issue) rd_ptr_d = rd_ptr_q + (ADDR_WIDTH + 1)'(1);
        if (pop) begin
          if (out_cnt_q == LAST_IDX) begin
            out_cnt_d = '0;
            rd_ptr_d  = '0;
            state_d   = ST_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      out_cnt_q    <= '0;
      ntt_start_q  <= 1'b0;
      wait_armed_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      out_cnt_q    <= out_cnt_d;
      ntt_start_q  <= ntt_start_d;
      wait_armed_q <= wait_armed_d;
      len_err_q    <= len_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_last_q     <= '0;
      fifo_wptr_q     <= 1'b0;
      fifo_rptr_q     <= 1'b0;
      fifo_cnt_q      <= '0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (issue) raddr_q <= issue_addr;
      if (push) begin
        fifo_last_q[fifo_wptr_q] <= inflight_last_q;
        fifo_wptr_q              <= ~fifo_wptr_q;
      end
      if (pop) fifo_rptr_q <= ~fifo_rptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Payload storage needs no reset; validity is carried by fifo_cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_data_q[fifo_wptr_q] <= ntt_read_data;
  end

endmodule
